rolling_window_feeder: RTL and testbench

Producer side of the rolling-average datapath. Accepts a stream of samples over a valid/ready handshake and keeps the last NUM_ELEM samples in a circular window. For every accepted sample it presents the new sample, the sample it evicts, and a one-cycle calc strobe, which drive the new/old/start inputs of the rolling-sum accumulator. A drain command walks the whole window out as "old" values, so the downstream sum returns to zero without resetting it.

---
 rtl/rolling_avg_pkg.sv | 22 ++
 rtl/window_buffer.sv | 40 ++++
 rtl/rolling_window_feeder.sv | 154 +++++++++++++++
 tb/tb_rolling_window_feeder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rolling_avg_pkg.sv
// ----------------------------------------------------------------------------
// rolling_avg_pkg
// Shared constants and types for the rolling-average datapath.
//   BITS_PER_ELEM : width of one sample
//   NUM_ELEM      : window depth (power of 2, >= 2)
//   PTR_BITS      : log2(NUM_ELEM), pointer width; fill count uses PTR_BITS+1
//   MAX_BITS      : width needed by the consumer to hold a full-window sum
//   feeder_state_e: feeder FSM states
// ----------------------------------------------------------------------------
package rolling_avg_pkg;

    localparam int BITS_PER_ELEM = 5;
    localparam int NUM_ELEM      = 8;
    localparam int PTR_BITS      = 3;
    localparam int MAX_BITS      = BITS_PER_ELEM + PTR_BITS;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } feeder_state_e;

endpackage

// File: rtl/window_buffer.sv
// ----------------------------------------------------------------------------
// window_buffer
// DEPTH x WIDTH register file holding the sliding window.
//   clk, rst_n : clock, asynchronous active-low clear of every entry
//   rd_addr    : read address; rd_data is combinational from it
//   wr_en      : write enable for wr_addr/wr_data on the rising edge
// ----------------------------------------------------------------------------
module window_buffer #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage array: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Combinational read port; the caller relies on seeing the pre-write value.
    always_comb begin
        rd_data = mem_q[rd_addr];
    end

endmodule

// File: rtl/rolling_window_feeder.sv
// ----------------------------------------------------------------------------
// rolling_window_feeder
// Producer side of the rolling-average datapath. Keeps the last NUM_ELEM
// accepted samples and, for every accepted sample, presents the new sample,
// the evicted sample and a one-cycle calc strobe. A flush walks the whole
// window out as "old" values so the downstream sum returns to zero.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_sample/i_valid: input sample stream, accepted when o_ready is high
//   o_ready         : high in RUN state
//   i_flush         : level request to drain the window (ignored in DRAIN)
//   o_new/o_old     : values entering/leaving the sum, valid with o_start_calc
//   o_start_calc    : one-cycle strobe
//   o_full          : window holds NUM_ELEM samples
//   o_draining      : drain in progress
// ----------------------------------------------------------------------------
module rolling_window_feeder
    import rolling_avg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BITS_PER_ELEM-1:0] i_sample,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_flush,
    output logic [BITS_PER_ELEM-1:0] o_new,
    output logic [BITS_PER_ELEM-1:0] o_old,
    output logic                     o_start_calc,
    output logic                     o_full,
    output logic                     o_draining
);

    localparam logic [PTR_BITS:0]   FILL_MAX  = (PTR_BITS+1)'(NUM_ELEM);
    localparam logic [PTR_BITS-1:0] DCNT_LAST = PTR_BITS'(NUM_ELEM - 1);
    localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);
    localparam logic [PTR_BITS:0]   FILL_ONE  = (PTR_BITS+1)'(1);

    feeder_state_e              state_q, state_d;
    logic [PTR_BITS-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0]          fill_cnt_q, fill_cnt_d;
    logic [PTR_BITS-1:0]        dcnt_q, dcnt_d;
    logic [BITS_PER_ELEM-1:0]   new_q, new_d;
    logic [BITS_PER_ELEM-1:0]   old_q, old_d;
    logic                       strobe_q, strobe_d;

    logic                       buf_wr_en_s;
    logic [BITS_PER_ELEM-1:0]   buf_wr_data_s;
    logic [BITS_PER_ELEM-1:0]   buf_rd_data_s;

    // Read and write share wr_ptr: the slot being overwritten is the one evicted.
    window_buffer #(
        .WIDTH (BITS_PER_ELEM),
        .DEPTH (NUM_ELEM),
        .AW    (PTR_BITS)
    ) u_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (wr_ptr_q),
        .rd_data (buf_rd_data_s),
        .wr_en   (buf_wr_en_s),
        .wr_addr (wr_ptr_q),
        .wr_data (buf_wr_data_s)
    );

    // Next-state logic: accept path in RUN, fixed-length zeroing walk in DRAIN.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        fill_cnt_d    = fill_cnt_q;
        dcnt_d        = dcnt_q;
        new_d         = new_q;
        old_d         = old_q;
        strobe_d      = 1'b0;
        buf_wr_en_s   = 1'b0;
        buf_wr_data_s = {BITS_PER_ELEM{1'b0}};

        case (state_q)
            RUN: begin
                if (i_valid) begin
                    new_d         = i_sample;
                    old_d         = buf_rd_data_s;
                    strobe_d      = 1'b1;
                    buf_wr_en_s   = 1'b1;
                    buf_wr_data_s = i_sample;
                    wr_ptr_d      = wr_ptr_q + PTR_ONE;
                    if (fill_cnt_q == FILL_MAX) begin
                        fill_cnt_d = fill_cnt_q;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FILL_ONE;
                    end
                end else begin
                    strobe_d = 1'b0;
                end
                // A same-cycle sample is written above, so the drain covers it.
                if (i_flush) begin
                    state_d = DRAIN;
                    dcnt_d  = {PTR_BITS{1'b0}};
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Every slot is strobed out, zero or not, so duration is fixed.
                new_d         = {BITS_PER_ELEM{1'b0}};
                old_d         = buf_rd_data_s;
                strobe_d      = 1'b1;
                buf_wr_en_s   = 1'b1;
                buf_wr_data_s = {BITS_PER_ELEM{1'b0}};
                wr_ptr_d      = wr_ptr_q + PTR_ONE;
                if (dcnt_q == DCNT_LAST) begin
                    state_d    = RUN;
                    fill_cnt_d = {(PTR_BITS+1){1'b0}};
                    dcnt_d     = {PTR_BITS{1'b0}};
                end else begin
                    dcnt_d = dcnt_q + PTR_ONE;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wr_ptr_q   <= {PTR_BITS{1'b0}};
            fill_cnt_q <= {(PTR_BITS+1){1'b0}};
            dcnt_q     <= {PTR_BITS{1'b0}};
            new_q      <= {BITS_PER_ELEM{1'b0}};
            old_q      <= {BITS_PER_ELEM{1'b0}};
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            dcnt_q     <= dcnt_d;
            new_q      <= new_d;
            old_q      <= old_d;
            strobe_q   <= strobe_d;
        end
    end

    // Output mapping; status flags decode directly from registered state.
    always_comb begin
        o_new        = new_q;
        o_old        = old_q;
        o_start_calc = strobe_q;
        o_ready      = (state_q == RUN);
        o_draining   = (state_q == DRAIN);
        o_full       = (fill_cnt_q == FILL_MAX);
    end

endmodule

// File: tb/tb_rolling_window_feeder.sv
module tb_rolling_window_feeder;
    import rolling_avg_pkg::*;

    logic                     clk;
    logic                     rst_n;
    logic [BITS_PER_ELEM-1:0] i_sample;
    logic                     i_valid;
    logic                     o_ready;
    logic                     i_flush;
    logic [BITS_PER_ELEM-1:0] o_new;
    logic [BITS_PER_ELEM-1:0] o_old;
    logic                     o_start_calc;
    logic                     o_full;
    logic                     o_draining;

    rolling_window_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sample     (i_sample),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_flush      (i_flush),
        .o_new        (o_new),
        .o_old        (o_old),
        .o_start_calc (o_start_calc),
        .o_full       (o_full),
        .o_draining   (o_draining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the window as a FIFO of the last NUM_ELEM values
    // (oldest at the front); a drain rotates zeros through it.
    int  mq[$];
    int  m_fill;
    bit  m_drain;
    int  m_dleft;
    bit  e_strobe;
    int  e_new;
    int  e_old;
    int  rsum;
    int  dsum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NUM_ELEM; i++) mq.push_back(0);
        m_fill = 0; m_drain = 0; m_dleft = 0;
        e_strobe = 0; e_new = 0; e_old = 0; rsum = 0;
    endtask

    task automatic model_cycle(input bit v, input int s, input bit f);
        if (!m_drain) begin
            if (v) begin
                e_old = mq.pop_front();
                mq.push_back(s);
                e_new = s;
                e_strobe = 1;
                if (m_fill < NUM_ELEM) m_fill++;
            end else begin
                e_strobe = 0;
            end
            if (f) begin
                m_drain = 1;
                m_dleft = NUM_ELEM;
            end
        end else begin
            e_old = mq.pop_front();
            mq.push_back(0);
            e_new = 0;
            e_strobe = 1;
            dsum += e_old;
            m_dleft--;
            if (m_dleft == 0) begin
                m_drain = 0;
                m_fill = 0;
            end
        end
        if (e_strobe) rsum += e_new - e_old;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".strobe"},   32'(o_start_calc), 32'(e_strobe));
        chk({tag, ".new"},      32'(o_new),        32'(e_new));
        chk({tag, ".old"},      32'(o_old),        32'(e_old));
        chk({tag, ".ready"},    32'(o_ready),      32'(!m_drain));
        chk({tag, ".full"},     32'(o_full),       32'(m_fill == NUM_ELEM));
        chk({tag, ".draining"}, 32'(o_draining),   32'(m_drain));
    endtask

    task automatic step(input string tag, input bit v, input int s, input bit f);
        i_valid  = v;
        i_sample = BITS_PER_ELEM'(s);
        i_flush  = f;
        @(posedge clk);
        #1;
        model_cycle(v, s, f);
        check_outputs(tag);
    endtask

    function automatic int window_sum();
        int t = 0;
        foreach (mq[i]) t += mq[i];
        return t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".new"},      32'(o_new),        32'd0);
        chk({tag, ".old"},      32'(o_old),        32'd0);
        chk({tag, ".strobe"},   32'(o_start_calc), 32'd0);
        chk({tag, ".full"},     32'(o_full),       32'd0);
        chk({tag, ".draining"}, 32'(o_draining),   32'd0);
        chk({tag, ".ready"},    32'(o_ready),      32'd1);
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_sample = '0; i_flush = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill phase: 1..8, evicted values are all zero
        for (int i = 1; i <= 8; i++) step("fill", 1, i, 0);
        // Steady state: 9,10 evict 1,2
        step("steady9", 1, 9, 0);
        step("steady10", 1, 10, 0);

        // Gapped input: valid every third cycle, outputs hold between strobes
        for (int k = 0; k < 9; k++) step("gap", (k % 3) == 0, 11 + k, 0);

        // Empty the window, then 3,5,7 and a drain
        step("flush0", 0, 0, 1);
        for (int i = 0; i < NUM_ELEM; i++) step("drain0", 0, 0, 0);
        chk("drain0.rsum", 32'(rsum), 32'd0);
        step("s3", 1, 3, 0);
        step("s5", 1, 5, 0);
        step("s7", 1, 7, 0);
        dsum = 0;
        step("flush1", 0, 0, 1);
        for (int i = 0; i < NUM_ELEM; i++) step("drain1", 1, 31, 1);
        chk("drain1.oldsum", 32'(dsum), 32'd15);
        chk("drain1.rsum", 32'(rsum), 32'd0);

        // Full window of 6s, then sample 4 together with flush
        for (int i = 0; i < NUM_ELEM; i++) step("six", 1, 6, 0);
        dsum = 0;
        step("vflush", 1, 4, 1);
        chk("vflush.new", 32'(o_new), 32'd4);
        chk("vflush.old", 32'(o_old), 32'd6);
        for (int i = 0; i < NUM_ELEM; i++) step("drain2", 0, 0, 0);
        chk("drain2.oldsum", 32'(dsum), 32'd46);
        chk("drain2.rsum", 32'(rsum), 32'd0);

        // Reset asserted in the middle of a drain
        for (int i = 0; i < 5; i++) step("pre", 1, 20 + i, 0);
        step("flush3", 0, 0, 1);
        for (int i = 0; i < 3; i++) step("drain3", 0, 0, 0);
        i_valid = 1'b0; i_flush = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("postreset", 1, 9, 0);
        chk("postreset.old0", 32'(o_old), 32'd0);

        // Randomized traffic with occasional flushes
        for (int n = 0; n < 400; n++) begin
            step("rand", $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                 $urandom_range(0, 24) == 0);
        end
        chk("final.invariant", 32'(rsum), 32'(window_sum()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
